window_gen: RTL and testbench

Parametrised F×F sliding-window generator for the filter datapath. It accepts a raster-order pixel stream, buffers F-1 image lines in internal line RAMs and presents a complete F×F neighbourhood every time an input pixel completes a fully-interior window. It sits between the pixel source and the convolution/filter cores and supersedes the fixed 3×3 window front-end, with per-pixel row/column tracking, exact output validity and frame resynchronisation.

---
 rtl/filter_pkg.sv | 20 ++
 rtl/window_gen_line_buffer.sv | 40 ++++
 rtl/window_gen.sv | 147 ++++++++++++++
 tb/tb_window_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Shared definitions for the filter datapath: default pixel width,
// counter-width helper and window element bit-offset mapping.
package filter_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit offset of window element (r,c); (0,0) sits in the MSBs.
  function automatic int unsigned win_offset(input int unsigned dw,
                                             input int unsigned f,
                                             input int unsigned r,
                                             input int unsigned c);
    return dw * (f * f - 1 - (r * f + c));
  endfunction

endpackage

// File: rtl/window_gen_line_buffer.sv
// Chained line buffer: LINES RAMs of DEPTH words addressed by column.
// Line 0 stores the incoming pixel, line k stores what line k-1 held at
// the same column. Reads are asynchronous so each output shows the value
// stored before the write at the current edge (read-before-write).
module line_buffer
  import filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned LINES      = 2,
  parameter int unsigned ADDR_W     = cnt_width(DEPTH)
) (
  input  logic                        clk,
  input  logic                        en,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_WIDTH-1:0]       din,
  output logic [DATA_WIDTH*LINES-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [LINES][DEPTH];

  // Present the old contents of every line at the current column.
  always_comb begin
    dout = '0;
    for (int unsigned k = 0; k < LINES; k++) begin
      dout[k*DATA_WIDTH +: DATA_WIDTH] = mem[k][addr];
    end
  end

  // Push the column one line deeper on each accepted pixel.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[0][addr] <= din;
      for (int unsigned k = 1; k < LINES; k++) begin
        mem[k][addr] <= mem[k-1][addr];
      end
    end
  end

endmodule

// File: rtl/window_gen.sv
// F x F sliding-window generator over a raster pixel stream.
// Optional WINDOW_GEN_EDGE_FLAGS_EN adds oSof/oEol window markers.
module window_gen
  import filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned F          = 3,
  parameter int unsigned IMG_WIDTH  = 8,
  parameter int unsigned IMG_HEIGHT = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         iValid,
  input  logic                         iSof,
  input  logic [DATA_WIDTH-1:0]        iData,
  output logic                         oValid,
`ifdef WINDOW_GEN_EDGE_FLAGS_EN
  output logic                         oSof,
  output logic                         oEol,
`endif
  output logic [DATA_WIDTH*F*F-1:0]    oData
);

  localparam int unsigned COL_W = cnt_width(IMG_WIDTH);
  localparam int unsigned ROW_W = cnt_width(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(F - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(F - 1);

  logic [COL_W-1:0]           col, cur_col;
  logic [ROW_W-1:0]           row, cur_row;
  logic                       in_window;
  logic [DATA_WIDTH*(F-1)-1:0] lb_out;
  logic [DATA_WIDTH-1:0]      new_col [F];
  logic [DATA_WIDTH-1:0]      win     [F][F];
  logic                       valid;

  // Position of the pixel on the input; start of frame forces (0,0).
  always_comb begin
    cur_col   = col;
    cur_row   = row;
    if (iValid && iSof) begin
      cur_col = '0;
      cur_row = '0;
    end
    in_window = (cur_row >= ROW_FIRST) && (cur_col >= COL_FIRST);
  end

  // Raster counters, advanced once per accepted pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (iValid) begin
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

  line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH),
    .LINES      (F - 1),
    .ADDR_W     (COL_W)
  ) u_line_buffer (
    .clk  (clk),
    .en   (iValid),
    .addr (cur_col),
    .din  (iData),
    .dout (lb_out)
  );

  // Incoming window column, oldest line at the top, live pixel at the bottom.
  always_comb begin
    for (int unsigned r = 0; r < F; r++) begin
      new_col[r] = '0;
    end
    for (int unsigned r = 0; r + 1 < F; r++) begin
      new_col[r] = lb_out[(F-2-r)*DATA_WIDTH +: DATA_WIDTH];
    end
    new_col[F-1] = iData;
  end

  // Window shift register: shift left and load the new right column.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < F; r++) begin
        for (int unsigned c = 0; c < F; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (iValid) begin
      for (int unsigned r = 0; r < F; r++) begin
        for (int unsigned c = 0; c + 1 < F; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][F-1] <= new_col[r];
      end
    end
  end

  // Window validity, registered alongside the window contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else begin
      valid <= iValid && in_window;
    end
  end

`ifdef WINDOW_GEN_EDGE_FLAGS_EN
  logic sof_flag, eol_flag;

  // First window of the frame and last window of each line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sof_flag <= 1'b0;
      eol_flag <= 1'b0;
    end else begin
      sof_flag <= iValid && (cur_row == ROW_FIRST) && (cur_col == COL_FIRST);
      eol_flag <= iValid && in_window && (cur_col == COL_LAST);
    end
  end

  assign oSof = sof_flag;
  assign oEol = eol_flag;
`endif

  // Flatten the window with element (0,0) in the MSBs.
  always_comb begin
    oData = '0;
    for (int unsigned r = 0; r < F; r++) begin
      for (int unsigned c = 0; c < F; c++) begin
        oData[win_offset(DATA_WIDTH, F, r, c) +: DATA_WIDTH] = win[r][c];
      end
    end
  end

  assign oValid = valid;

endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen (F=3, 8x6 image, pixel = 16*row+col).
// Honours WINDOW_GEN_EDGE_FLAGS_EN to also check oSof/oEol.
module tb_window_gen;

  localparam int DW = 16;
  localparam int F  = 3;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int WW = DW * F * F;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          iValid = 1'b0;
  logic          iSof = 1'b0;
  logic [DW-1:0] iData = '0;
  logic          oValid;
  logic [WW-1:0] oData;
`ifdef WINDOW_GEN_EDGE_FLAGS_EN
  logic          oSof, oEol;
`endif

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  logic [WW-1:0] last_win = '0;
  bit            last_ok  = 1'b0;

  window_gen #(
    .DATA_WIDTH (DW),
    .F          (F),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .iValid (iValid),
    .iSof   (iSof),
    .iData  (iData),
    .oValid (oValid),
`ifdef WINDOW_GEN_EDGE_FLAGS_EN
    .oSof   (oSof),
    .oEol   (oEol),
`endif
    .oData  (oData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Window completed by pixel (r,c): element (i,j) = pixel (r-2+i, c-2+j).
  function automatic logic [WW-1:0] expwin(input int r, input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < F; i++)
      for (int j = 0; j < F; j++)
        w[DW*(F*F-1-(i*F+j)) +: DW] = DW'(16*(r-F+1+i) + (c-F+1+j));
    return w;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " valid"}, WW'(oValid), '0);
`ifdef WINDOW_GEN_EDGE_FLAGS_EN
    check({tag, " sof"}, WW'(oSof), '0);
    check({tag, " eol"}, WW'(oEol), '0);
`endif
  endtask

  // Present pixel (r,c), optionally preceded by a few idle cycles.
  task automatic send(input int r, input int c, input bit sof, input bit gaps);
    bit ev;
    int n;
    n = 0;
    while (gaps && n < 4 && $urandom_range(0, 1) == 1) begin
      iValid = 1'b0;
      iSof   = 1'($urandom_range(0, 1));
      iData  = 16'hdead;
      @(posedge clk); #1;
      check_idle($sformatf("gap r%0d c%0d", r, c));
      if (last_ok) check($sformatf("hold r%0d c%0d", r, c), oData, last_win);
      n++;
    end
    iValid = 1'b1;
    iSof   = sof;
    iData  = DW'(16*r + c);
    @(posedge clk); #1;
    ev = (r >= F-1) && (c >= F-1);
    check($sformatf("valid r%0d c%0d", r, c), WW'(oValid), WW'(ev));
    if (ev) begin
      check($sformatf("win r%0d c%0d", r, c), oData, expwin(r, c));
      pulses++;
      last_win = expwin(r, c);
    end
    last_ok = ev;
`ifdef WINDOW_GEN_EDGE_FLAGS_EN
    check($sformatf("sof r%0d c%0d", r, c), WW'(oSof), WW'(r == F-1 && c == F-1));
    check($sformatf("eol r%0d c%0d", r, c), WW'(oEol), WW'(ev && c == W-1));
`endif
  endtask

  task automatic send_frame(input string tag, input bit sof, input bit gaps);
    pulses = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send(r, c, sof && r == 0 && c == 0, gaps);
    check({tag, " pulses"}, WW'(pulses), WW'((H-F+1)*(W-F+1)));
  endtask

  task automatic do_reset(input string tag);
    rst_n  = 1'b0;
    iValid = 1'b1;
    iSof   = 1'b0;
    iData  = 16'h5555;
    @(posedge clk); #1;
    check_idle(tag);
    check({tag, " data"}, oData, '0);
    rst_n   = 1'b1;
    last_ok = 1'b0;
  endtask

  initial begin
    logic [WW-1:0] first_win;
    logic [WW-1:0] wrap_win;
    first_win = 144'h0000_0001_0002_0010_0011_0012_0020_0021_0022;
    wrap_win  = 144'h0010_0011_0012_0020_0021_0022_0030_0031_0032;

    // Power-on reset.
    @(posedge clk); #1;
    do_reset("reset");

    // Continuous frame with explicit first and line-wrap windows.
    pulses = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send(r, c, r == 0 && c == 0, 1'b0);
        if (r == 2 && c == 2) check("first window", oData, first_win);
        if (r == 3 && c == 2) check("row3 window", oData, wrap_win);
      end
    check("frame1 pulses", WW'(pulses), WW'(24));

    // Gapped frame, then a back-to-back continuous frame.
    send_frame("gapped", 1'b1, 1'b1);
    send_frame("b2b", 1'b1, 1'b0);

    // Resynchronise at counter position (3,5).
    pulses = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++)
        if (r < 3 || c < 5) send(r, c, r == 0 && c == 0, 1'b0);
    check("pre-resync pulses", WW'(pulses), WW'(9));
    send_frame("resync", 1'b1, 1'b0);

    // Reset in row 4, restart without iSof.
    pulses = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < W; c++)
        if (r < 4 || c < 4) send(r, c, r == 0 && c == 0, 1'b0);
    check("pre-reset pulses", WW'(pulses), WW'(14));
    do_reset("mid reset");
    send_frame("after reset", 1'b0, 1'b0);

    iValid = 1'b0;
    iSof   = 1'b0;
    @(posedge clk); #1;
    check_idle("tail");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
